div_seq: RTL and testbench



---
 rtl/div_pkg.sv | 20 ++
 rtl/div_seq_if.sv | 35 +++
 rtl/div_step.sv | 28 ++
 rtl/div_seq.sv | 159 +++++++++++++++
 tb/tb_div_seq.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider.
//   div_state_e : FSM state encoding (IDLE, RUN, DONE)
//   DEF_WIDTH   : default divisor/quotient/remainder width
//   cnt_width() : width of the iteration counter for a given WIDTH
package div_pkg;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_RUN  = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

  localparam int DEF_WIDTH = 8;

  // The counter must be able to hold the value WIDTH itself.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/div_seq_if.sv
// Handshake/operand bundle for div_seq.
//   master : drives start, dividend (2*WIDTH), divisor (WIDTH) [, sgn]
//   slave  : drives busy, done, quotient, remainder, dbz, ovf
// Optional feature macro: DIV_SIGNED_EN adds the sgn request bit.
interface div_seq_if
  import div_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);
  logic               start;
  logic [2*WIDTH-1:0] dividend;
  logic [WIDTH-1:0]   divisor;
`ifdef DIV_SIGNED_EN
  logic               sgn;
`endif
  logic               busy;
  logic               done;
  logic [WIDTH-1:0]   quotient;
  logic [WIDTH-1:0]   remainder;
  logic               dbz;
  logic               ovf;

`ifdef DIV_SIGNED_EN
  modport master (output start, dividend, divisor, sgn,
                  input  busy, done, quotient, remainder, dbz, ovf);
  modport slave  (input  start, dividend, divisor, sgn,
                  output busy, done, quotient, remainder, dbz, ovf);
`else
  modport master (output start, dividend, divisor,
                  input  busy, done, quotient, remainder, dbz, ovf);
  modport slave  (input  start, dividend, divisor,
                  output busy, done, quotient, remainder, dbz, ovf);
`endif

endinterface

// File: rtl/div_step.sv
// One combinational restoring-division iteration.
//   r       in  WIDTH+1  current partial remainder (always < divisor)
//   q_msb   in  1        bit shifted in from the dividend/quotient register
//   divisor in  WIDTH    divisor
//   r_next  out WIDTH+1  partial remainder after this step
//   q_bit   out 1        quotient bit produced by this step
module div_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH:0]   r,
  input  logic             q_msb,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   r_next,
  output logic             q_bit
);

  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] diff;

  always_comb begin
    shifted = {r, q_msb};
    diff    = shifted - {2'b00, divisor};
    q_bit   = (shifted >= {2'b00, divisor});
    // Because r < divisor on entry, the kept value always fits in WIDTH+1 bits.
    r_next  = (WIDTH+1)'(q_bit ? diff : shifted);
  end

endmodule

// File: rtl/div_seq.sv
// Sequential restoring divider: 2*WIDTH-bit dividend / WIDTH-bit divisor,
// one quotient bit per clock, start/busy/done handshake.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset (aborts a running division)
//   bus   : div_seq_if slave (start/dividend/divisor in; busy/done/
//           quotient/remainder/dbz/ovf out)
// Optional feature macro: DIV_SIGNED_EN (two's-complement operands selected
// by bus.sgn, truncating C-style results).
module div_seq
  import div_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input logic     clk,
  input logic     rst_n,
  div_seq_if.slave bus
);

  localparam int CW = cnt_width(WIDTH);

  localparam logic [1:0] S_IDLE = 2'(DIV_IDLE);
  localparam logic [1:0] S_RUN  = 2'(DIV_RUN);
  localparam logic [1:0] S_DONE = 2'(DIV_DONE);

  logic [1:0]         state_reg;
  logic [WIDTH:0]     r_reg;
  logic [WIDTH-1:0]   q_reg;
  logic [WIDTH-1:0]   dv_reg;
  logic [CW-1:0]      cnt_reg;
  logic               done_reg;
  logic [WIDTH-1:0]   quotient_reg;
  logic [WIDTH-1:0]   remainder_reg;
  logic               dbz_reg;
  logic               ovf_reg;

  logic [2*WIDTH-1:0] dd_mag;
  logic [WIDTH-1:0]   dv_mag;
  logic [WIDTH:0]     r_next;
  logic               q_bit;

`ifdef DIV_SIGNED_EN
  logic               neg_q_reg;
  logic               neg_r_reg;
  logic               sd;
  logic               sv;
  logic               sovf;

  // The datapath always divides magnitudes; signs are re-applied in DONE.
  always_comb begin
    sd     = bus.sgn & bus.dividend[2*WIDTH-1];
    sv     = bus.sgn & bus.divisor[WIDTH-1];
    dd_mag = sd ? -bus.dividend : bus.dividend;
    dv_mag = sv ? -bus.divisor  : bus.divisor;
    // A negative result may reach 2^(W-1); a positive one only 2^(W-1)-1.
    sovf   = neg_q_reg ? (q_reg > {1'b1, {(WIDTH-1){1'b0}}})
                       : (q_reg > {1'b0, {(WIDTH-1){1'b1}}});
  end
`else
  always_comb begin
    dd_mag = bus.dividend;
    dv_mag = bus.divisor;
  end
`endif

  div_step #(.WIDTH(WIDTH)) u_step (
    .r       (r_reg),
    .q_msb   (q_reg[WIDTH-1]),
    .divisor (dv_reg),
    .r_next  (r_next),
    .q_bit   (q_bit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= S_IDLE;
      r_reg         <= '0;
      q_reg         <= '0;
      dv_reg        <= '0;
      cnt_reg       <= '0;
      done_reg      <= 1'b0;
      quotient_reg  <= '0;
      remainder_reg <= '0;
      dbz_reg       <= 1'b0;
      ovf_reg       <= 1'b0;
`ifdef DIV_SIGNED_EN
      neg_q_reg     <= 1'b0;
      neg_r_reg     <= 1'b0;
`endif
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (bus.start) begin
            dv_reg <= dv_mag;
`ifdef DIV_SIGNED_EN
            neg_q_reg <= sd ^ sv;
            neg_r_reg <= sd;
`endif
            if (dv_mag == '0) begin
              dbz_reg   <= 1'b1;
              ovf_reg   <= 1'b0;
              q_reg     <= '1;
              r_reg     <= '0;
              state_reg <= S_DONE;
            end else if (dd_mag[2*WIDTH-1:WIDTH] >= dv_mag) begin
              // Quotient would not fit in WIDTH bits.
              dbz_reg   <= 1'b0;
              ovf_reg   <= 1'b1;
              q_reg     <= '1;
              r_reg     <= '0;
              state_reg <= S_DONE;
            end else begin
              dbz_reg   <= 1'b0;
              ovf_reg   <= 1'b0;
              r_reg     <= {1'b0, dd_mag[2*WIDTH-1:WIDTH]};
              q_reg     <= dd_mag[WIDTH-1:0];
              cnt_reg   <= CW'(WIDTH);
              state_reg <= S_RUN;
            end
          end
        end
        S_RUN: begin
          r_reg   <= r_next;
          q_reg   <= {q_reg[WIDTH-2:0], q_bit};
          cnt_reg <= cnt_reg - CW'(1);
          if (cnt_reg == CW'(1)) begin
            state_reg <= S_DONE;
          end
        end
        S_DONE: begin
          done_reg  <= 1'b1;
          state_reg <= S_IDLE;
`ifdef DIV_SIGNED_EN
          if (dbz_reg || ovf_reg) begin
            quotient_reg  <= q_reg;
            remainder_reg <= r_reg[WIDTH-1:0];
          end else begin
            quotient_reg  <= neg_q_reg ? -q_reg : q_reg;
            remainder_reg <= neg_r_reg ? -r_reg[WIDTH-1:0] : r_reg[WIDTH-1:0];
            ovf_reg       <= sovf;
          end
`else
          quotient_reg  <= q_reg;
          remainder_reg <= r_reg[WIDTH-1:0];
`endif
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign bus.busy      = (state_reg == S_RUN);
  assign bus.done      = done_reg;
  assign bus.quotient  = quotient_reg;
  assign bus.remainder = remainder_reg;
  assign bus.dbz       = dbz_reg;
  assign bus.ovf       = ovf_reg;

endmodule

// File: tb/tb_div_seq.sv
// Directed bench for div_seq: hand-computed vectors, latency, hold,
// ignored/held start, mid-run reset and (with DIV_SIGNED_EN) signed cases.
module tb_div_seq;
  import div_pkg::*;

  localparam int W = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  div_seq_if #(.WIDTH(W)) bus();

  div_seq #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present operands with start for one accepting edge, then drop start.
  task automatic kick(input logic [15:0] dd, input logic [7:0] dv);
    @(negedge clk);
    bus.dividend = dd;
    bus.divisor  = dv;
    bus.start    = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  // Edges counted until done is seen; bounded so a stuck DUT cannot hang.
  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!bus.done && n < 30);
  endtask

  task automatic count_dones(input int k, output int c);
    c = 0;
    repeat (k) begin
      @(posedge clk);
      #1;
      if (bus.done) c++;
    end
  endtask

  task automatic run_chk(input string tag, input logic [15:0] dd, input logic [7:0] dv,
                         input int lat, input logic [7:0] q, input logic [7:0] r,
                         input logic dz, input logic ov);
    int n;
    kick(dd, dv);
    wait_done(n);
    $display("txn %s: %0d/%0d lat=%0d q=0x%0h r=0x%0h dbz=%0b ovf=%0b",
             tag, dd, dv, n, bus.quotient, bus.remainder, bus.dbz, bus.ovf);
    check({tag, " latency"}, n, lat);
    check({tag, " quotient"}, bus.quotient, q);
    check({tag, " remainder"}, bus.remainder, r);
    check({tag, " dbz"}, bus.dbz, dz);
    check({tag, " ovf"}, bus.ovf, ov);
    @(posedge clk);
    #1;
    check({tag, " done pulse"}, bus.done, 1'b0);
    check({tag, " q held"}, bus.quotient, q);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int c;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
`ifdef DIV_SIGNED_EN
    bus.sgn      = 1'b0;
`endif
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset busy", bus.busy, 1'b0);
    check("reset done", bus.done, 1'b0);
    check("reset quotient", bus.quotient, 8'h00);
    check("reset remainder", bus.remainder, 8'h00);
    check("reset dbz", bus.dbz, 1'b0);
    check("reset ovf", bus.ovf, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    run_chk("3375/15", 16'd3375, 8'd15, 9, 8'd225, 8'd0, 1'b0, 1'b0);
    run_chk("1000/7", 16'd1000, 8'd7, 9, 8'd142, 8'd6, 1'b0, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    check("1000/7 q hold", bus.quotient, 8'd142);
    check("1000/7 r hold", bus.remainder, 8'd6);
    run_chk("0/5", 16'd0, 8'd5, 9, 8'd0, 8'd0, 1'b0, 1'b0);
    run_chk("255/1", 16'h00FF, 8'd1, 9, 8'd255, 8'd0, 1'b0, 1'b0);
    run_chk("65279/255", 16'hFEFF, 8'd255, 9, 8'd255, 8'd254, 1'b0, 1'b0);
    run_chk("dbz", 16'h1234, 8'h00, 1, 8'hFF, 8'h00, 1'b1, 1'b0);
    run_chk("ovf", 16'h1234, 8'h12, 1, 8'hFF, 8'h00, 1'b0, 1'b1);

    // start pulsed during RUN cycle 4 must be dropped.
    kick(16'd1000, 8'd7);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    check("ign busy", bus.busy, 1'b1);
    bus.start   = 1'b1;
    bus.divisor = 8'd3;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_done(n);
    $display("txn ignored-start: lat_rest=%0d q=0x%0h r=0x%0h", n, bus.quotient, bus.remainder);
    check("ign latency", n, 5);
    check("ign quotient", bus.quotient, 8'd142);
    check("ign remainder", bus.remainder, 8'd6);
    check("ign flags", {bus.dbz, bus.ovf}, 2'b00);
    count_dones(15, c);
    check("ign single done", c, 0);
    check("ign idle", bus.busy, 1'b0);

    // start held high: re-accepted right after done.
    @(negedge clk);
    bus.dividend = 16'd3375;
    bus.divisor  = 8'd15;
    bus.start    = 1'b1;
    @(posedge clk);
    #1;
    bus.dividend = 16'd1000;
    bus.divisor  = 8'd7;
    wait_done(n);
    $display("txn held-start #1: lat=%0d q=0x%0h", n, bus.quotient);
    check("held1 latency", n, 9);
    check("held1 quotient", bus.quotient, 8'd225);
    wait_done(n);
    bus.start = 1'b0;
    $display("txn held-start #2: lat=%0d q=0x%0h r=0x%0h", n, bus.quotient, bus.remainder);
    check("held2 latency", n, 10);
    check("held2 quotient", bus.quotient, 8'd142);
    check("held2 remainder", bus.remainder, 8'd6);
    count_dones(12, c);
    check("held no third", c, 0);

    // Reset during RUN cycle 5 aborts with no done.
    kick(16'd3375, 8'd15);
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    #1;
    $display("txn mid-run reset: q=0x%0h r=0x%0h busy=%0b", bus.quotient, bus.remainder, bus.busy);
    check("rst quotient", bus.quotient, 8'h00);
    check("rst remainder", bus.remainder, 8'h00);
    check("rst busy", bus.busy, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    count_dones(12, c);
    check("rst no done", c, 0);
    run_chk("65535/255", 16'hFFFF, 8'hFF, 1, 8'hFF, 8'h00, 1'b0, 1'b1);

`ifdef DIV_SIGNED_EN
    bus.sgn = 1'b1;
    run_chk("-100/7", 16'hFF9C, 8'd7, 9, 8'hF2, 8'hFE, 1'b0, 1'b0);
    run_chk("100/-7", 16'd100, 8'hF9, 9, 8'hF2, 8'h02, 1'b0, 1'b0);
    run_chk("-32768/-128", 16'h8000, 8'h80, 1, 8'hFF, 8'h00, 1'b0, 1'b1);
    bus.sgn = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
